// File: rtl/chunk_buffer_ctrl_pkg.sv
// chunk_buffer_ctrl_pkg
//   Shared constants for the ping-pong chunk buffer and the processor that
//   consumes it: default sample width, default chunk length and the number of
//   chunks the playback path stays muted after reset.
//   Also provides the saturating increment used by the mute counter.
package chunk_buffer_ctrl_pkg;

  localparam int DEF_SAMPLE_SIZE  = 24;
  localparam int DEF_IO_BUFF_SIZE = 64;

  // Output banks hold garbage until the processor has filled one; that takes
  // two completed chunks after reset.
  localparam int MUTE_CHUNKS = 2;

  typedef logic [1:0] primed_t;

  function automatic primed_t primed_inc(input primed_t cnt);
    return (cnt == 2'b11) ? cnt : cnt + 2'b01;
  endfunction

endpackage

// File: rtl/chunk_buffer_ctrl_ram.sv
// chunk_bank_ram
//   Two banks of DEPTH words, addressed as {bank, ptr}.
//   Ports:
//     clk              write clock
//     wr_en            write strobe
//     wr_bank, wr_ptr  write address
//     wr_data          write data
//     rd_bank, rd_ptr  read address (asynchronous read)
//     rd_data          read data, combinational from the read address
module chunk_bank_ram #(
  parameter int WIDTH    = 24,
  parameter int DEPTH    = 64,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic                wr_bank,
  input  logic [PTR_BITS-1:0] wr_ptr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_bank,
  input  logic [PTR_BITS-1:0] rd_ptr,
  output logic [WIDTH-1:0]    rd_data
);

  logic [WIDTH-1:0] mem [2*DEPTH];

  // NOTE: storage arrays get no reset branch; a reset would turn the array
  // into flops instead of RAM, and stale contents are harmless because the
  // control logic mutes playback until every word has been rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_ptr}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_bank, rd_ptr}];

endmodule

// File: rtl/chunk_buffer_ctrl.sv
// chunk_buffer_ctrl
//   Ping-pong chunk buffer between a sample stream and a block processor.
//   Incoming samples are captured into the capture bank while the matching
//   playback bank is streamed out in lockstep. Each completed chunk swaps the
//   banks and is announced with chunk_pulse; the processor then reads inputs
//   and writes results on the other bank.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     in_sample, in_valid        capture stream
//     out_sample, out_valid      playback stream, one cycle after in_valid
//     chunk_pulse                one-cycle pulse: new chunk ready
//     input_buff_ptr/_sample     processor read port (combinational)
//     output_buff_ptr/_sample,
//     output_buff_write_pulse    processor write port
//     proc_busy                  processing bank not yet finished
//     overrun                    sticky: chunk completed while still busy
module chunk_buffer_ctrl
  import chunk_buffer_ctrl_pkg::*;
#(
  parameter int SAMPLE_SIZE      = DEF_SAMPLE_SIZE,
  parameter int IO_BUFF_SIZE     = DEF_IO_BUFF_SIZE,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SAMPLE_SIZE-1:0]      in_sample,
  input  logic                        in_valid,
  output logic [SAMPLE_SIZE-1:0]      out_sample,
  output logic                        out_valid,
  output logic                        chunk_pulse,
  input  logic [IO_BUFF_PTR_BITS-1:0] input_buff_ptr,
  output logic [SAMPLE_SIZE-1:0]      input_buff_sample,
  input  logic [IO_BUFF_PTR_BITS-1:0] output_buff_ptr,
  input  logic [SAMPLE_SIZE-1:0]      output_buff_sample,
  input  logic                        output_buff_write_pulse,
  output logic                        proc_busy,
  output logic                        overrun
);

  localparam logic [IO_BUFF_PTR_BITS-1:0] LAST_PTR = IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);
  localparam logic [IO_BUFF_PTR_BITS-1:0] PTR_ONE  = IO_BUFF_PTR_BITS'(1);
  localparam primed_t                     UNMUTE   = primed_t'(MUTE_CHUNKS);

  logic [IO_BUFF_PTR_BITS-1:0] wr_ptr;
  logic                        bank;
  primed_t                     primed_cnt;
  logic [SAMPLE_SIZE-1:0]      play_sample;

  logic proc_bank;
  logic boundary;
  logic last_write;
  logic muted;

  assign proc_bank  = ~bank;
  assign boundary   = in_valid && (wr_ptr == LAST_PTR);
  assign last_write = output_buff_write_pulse && (output_buff_ptr == LAST_PTR);
  assign muted      = (primed_cnt < UNMUTE);

  chunk_bank_ram #(
    .WIDTH    (SAMPLE_SIZE),
    .DEPTH    (IO_BUFF_SIZE),
    .PTR_BITS (IO_BUFF_PTR_BITS)
  ) u_in_mem (
    .clk     (clk),
    .wr_en   (in_valid),
    .wr_bank (bank),
    .wr_ptr  (wr_ptr),
    .wr_data (in_sample),
    .rd_bank (proc_bank),
    .rd_ptr  (input_buff_ptr),
    .rd_data (input_buff_sample)
  );

  // The processor write uses the bank as it was before this edge, so a write
  // coinciding with a chunk boundary still lands in the bank it was meant for.
  chunk_bank_ram #(
    .WIDTH    (SAMPLE_SIZE),
    .DEPTH    (IO_BUFF_SIZE),
    .PTR_BITS (IO_BUFF_PTR_BITS)
  ) u_out_mem (
    .clk     (clk),
    .wr_en   (output_buff_write_pulse),
    .wr_bank (proc_bank),
    .wr_ptr  (output_buff_ptr),
    .wr_data (output_buff_sample),
    .rd_bank (bank),
    .rd_ptr  (wr_ptr),
    .rd_data (play_sample)
  );

  // NOTE: every register here uses <= so all updates see the pre-edge values
  // of bank, wr_ptr and proc_busy, which the boundary/write collision relies on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      bank        <= 1'b0;
      primed_cnt  <= '0;
      out_sample  <= '0;
      out_valid   <= 1'b0;
      chunk_pulse <= 1'b0;
      proc_busy   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      out_valid   <= in_valid;
      chunk_pulse <= boundary;

      if (in_valid) begin
        out_sample <= muted ? '0 : play_sample;
        wr_ptr     <= wr_ptr + PTR_ONE;  // power-of-two depth: wraps at the boundary
      end

      if (boundary) begin
        bank       <= ~bank;
        primed_cnt <= primed_inc(primed_cnt);
      end

      // A new chunk outranks the processor finishing the previous one.
      if (boundary) begin
        proc_busy <= 1'b1;
      end else if (last_write) begin
        proc_busy <= 1'b0;
      end

      // A last-index write on the boundary edge counts as finishing in time.
      if (boundary && proc_busy && !last_write) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
